// File: rtl/q1_moore_post_synth_if.sv
// Serial detector bus: one data bit in, one detect flag out.
interface q1_moore_post_synth_if;
  logic j;  // serial data bit, sampled on the rising clock edge
  logic w;  // detect flag for "1001"

  // The stimulus side drives the bit and watches the flag.
  modport master (output j, input w);
  // The detector consumes the bit and produces the flag.
  modport slave (input j, output w);
endinterface

// File: rtl/q1_moore_post_synth.sv
// Overlapping "1001" serial sequence detector.
// MEALY = 0: Moore style. Five states, and w is decoded from the state register.
//   A detect pulse appears in the cycle after the edge that samples the final '1'.
// MEALY = 1: Mealy style. Four states, and w = (state == S3) & j, purely combinational.
//   A detect pulse appears while the final '1' is still on the input.
// A Moore/Mealy pair fed the same bit stream gives pulses exactly one cycle apart.
module q1_moore_post_synth #(
  parameter bit MEALY = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  q1_moore_post_synth_if.slave det
);

  // S4 is the only state with bit 2 set, so the Moore flag is one flop output.
  // That keeps it free of decode glitches.
  // The 2-state base type powers up as all-zero, which is S0.
  // The flag therefore has a defined value even if rst is never asserted.
  typedef enum bit [2:0] {
    S0 = 3'b000,  // nothing matched
    S1 = 3'b001,  // "1"
    S2 = 3'b010,  // "10"
    S3 = 3'b011,  // "100"
    S4 = 3'b100   // "1001" complete (Moore only)
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   w_d;

  // State register with synchronous reset; rst wins over j at the same edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state transitions and the detect flag for the selected output style.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d = state_q;
    w_d     = 1'b0;

    case (state_q)
      S0:      state_d = det.j ? S1 : S0;
      S1:      state_d = det.j ? S1 : S2;
      S2:      state_d = det.j ? S1 : S3;
      // On the completing '1', Moore parks in S4 for one cycle.
      // Mealy reports the match immediately and reuses the trailing '1' as S1.
      S3:      state_d = det.j ? (MEALY ? S1 : S4) : S0;
      // The trailing '1' of a match can start the next match.
      S4:      state_d = det.j ? S1 : S2;
      default: state_d = S0;
    endcase

    if (MEALY) begin
      w_d = (state_q == S3) && det.j;
    end else begin
      w_d = state_q[2];
    end
  end

  assign det.w = w_d;

endmodule

// File: tb/tb_q1_moore_post_synth.sv
// Directed bench for a Moore/Mealy pair of "1001" detectors sharing one input.
// j and rst change on falling edges.
// Both flags are sampled 5 ns later, well away from the rising edge.
// At that sample point the Mealy flag reflects the bit now on j.
// The Moore flag reflects the match completed at the previous rising edge.
module tb_q1_moore_post_synth;

  logic clk;
  logic rst;

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected Moore flag at the next sample, carried across tasks.
  logic moore_exp = 1'b0;

  q1_moore_post_synth_if moore_if ();
  q1_moore_post_synth_if mealy_if ();

  q1_moore_post_synth #(.MEALY(1'b0)) u_moore (
    .clk (clk),
    .rst (rst),
    .det (moore_if.slave)
  );

  q1_moore_post_synth #(.MEALY(1'b1)) u_mealy (
    .clk (clk),
    .rst (rst),
    .det (mealy_if.slave)
  );

  // 50 ns bit period: rising edges at 25, 75, ...; falling edges at 50, 100, ...
  initial begin
    clk = 1'b0;
    forever #25 clk = ~clk;
  end

  // Present one bit (and rst) on the falling edge, then settle before sampling.
  task automatic step(input logic jv, input logic rv);
    @(negedge clk);
    moore_if.j = jv;
    mealy_if.j = jv;
    rst        = rv;
    #5;
  endtask

  // Power-up without rst: flags must be defined at once.
  // The overlap stream must then detect at bits 5 and 10.
  task automatic test_no_reset_start();
    logic [11:0] j_v = 12'b0100_1010_0100;
    logic [11:0] e_v = 12'b0000_1000_0100;
    #1;
    tests_run++;
    if ($isunknown(moore_if.w) || $isunknown(mealy_if.w)) begin
      tests_failed++;
      $display("FAIL no_reset_x_at_start: moore w=%b mealy w=%b, required defined 0", moore_if.w, mealy_if.w);
    end
    for (int i = 11; i >= 0; i--) begin
      step(j_v[i], 1'b0);
      tests_run++;
      if (mealy_if.w !== e_v[i]) begin
        tests_failed++;
        $display("FAIL no_reset_mealy bit %0d: got %b required %b", 12 - i, mealy_if.w, e_v[i]);
      end
      tests_run++;
      if (moore_if.w !== moore_exp) begin
        tests_failed++;
        $display("FAIL no_reset_moore bit %0d: got %b required %b", 12 - i, moore_if.w, moore_exp);
      end
      moore_exp = e_v[i];
    end
  endtask

  // Start in S3 ("100"), then hold rst for two edges; j=1 on the second edge.
  // rst must dominate there, so the following "001" must not complete a match.
  task automatic test_reset();
    logic [5:0] j_v = 6'b010010;
    logic [5:0] r_v = 6'b110000;
    for (int i = 5; i >= 0; i--) begin
      step(j_v[i], r_v[i]);
      tests_run++;
      if (mealy_if.w !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_mealy step %0d: got %b required 0", 6 - i, mealy_if.w);
      end
      tests_run++;
      if (moore_if.w !== moore_exp) begin
        tests_failed++;
        $display("FAIL reset_moore step %0d: got %b required %b", 6 - i, moore_if.w, moore_exp);
      end
      moore_exp = 1'b0;
    end
  endtask

  // Basic match: reset, then 0,1,0,0,1, then 0.
  // Mealy detects on the 5th bit; Moore detects one cycle later.
  task automatic test_basic_match();
    logic [6:0] j_v = 7'b0_01001_0;
    logic [6:0] r_v = 7'b1_00000_0;
    logic [6:0] e_v = 7'b0_00001_0;
    for (int i = 6; i >= 0; i--) begin
      step(j_v[i], r_v[i]);
      tests_run++;
      if (mealy_if.w !== e_v[i]) begin
        tests_failed++;
        $display("FAIL basic_mealy step %0d: got %b required %b", 7 - i, mealy_if.w, e_v[i]);
      end
      tests_run++;
      if (moore_if.w !== moore_exp) begin
        tests_failed++;
        $display("FAIL basic_moore step %0d: got %b required %b", 7 - i, moore_if.w, moore_exp);
      end
      moore_exp = e_v[i] & ~r_v[i];
    end
  endtask

  // Overlap stream after reset: two pulses per style, and the OR of the pair
  // must form two 2-cycle windows. Then "1001001" detects at bits 4 and 7.
  task automatic test_overlap();
    logic [12:0] j_v = 13'b0_0100_1010_0100;
    logic [12:0] r_v = 13'b1_0000_0000_0000;
    logic [12:0] e_v = 13'b0_0000_1000_0100;
    logic [8:0]  j2_v = 9'b0_1001001_0;
    logic [8:0]  r2_v = 9'b1_0000000_0;
    logic [8:0]  e2_v = 9'b0_0001001_0;
    int mealy_cnt = 0;
    int moore_cnt = 0;
    int or_cnt    = 0;
    for (int i = 12; i >= 0; i--) begin
      step(j_v[i], r_v[i]);
      if (mealy_if.w === 1'b1) mealy_cnt++;
      if (moore_if.w === 1'b1) moore_cnt++;
      if ((mealy_if.w | moore_if.w) === 1'b1) or_cnt++;
      tests_run++;
      if (mealy_if.w !== e_v[i]) begin
        tests_failed++;
        $display("FAIL overlap_mealy step %0d: got %b required %b", 13 - i, mealy_if.w, e_v[i]);
      end
      tests_run++;
      if (moore_if.w !== moore_exp) begin
        tests_failed++;
        $display("FAIL overlap_moore step %0d: got %b required %b", 13 - i, moore_if.w, moore_exp);
      end
      tests_run++;
      if ((mealy_if.w | moore_if.w) !== (e_v[i] | moore_exp)) begin
        tests_failed++;
        $display("FAIL overlap_or step %0d: got %b required %b", 13 - i, mealy_if.w | moore_if.w, e_v[i] | moore_exp);
      end
      moore_exp = e_v[i] & ~r_v[i];
    end
    tests_run++;
    if (mealy_cnt != 2 || moore_cnt != 2 || or_cnt != 4) begin
      tests_failed++;
      $display("FAIL overlap_pulse_counts: mealy=%0d moore=%0d or=%0d required 2/2/4", mealy_cnt, moore_cnt, or_cnt);
    end
    for (int i = 8; i >= 0; i--) begin
      step(j2_v[i], r2_v[i]);
      tests_run++;
      if (mealy_if.w !== e2_v[i]) begin
        tests_failed++;
        $display("FAIL overlap1001001_mealy step %0d: got %b required %b", 9 - i, mealy_if.w, e2_v[i]);
      end
      tests_run++;
      if (moore_if.w !== moore_exp) begin
        tests_failed++;
        $display("FAIL overlap1001001_moore step %0d: got %b required %b", 9 - i, moore_if.w, moore_exp);
      end
      moore_exp = e2_v[i] & ~r2_v[i];
    end
  endtask

  // Near misses "1011", "1000", "0001", "10001" stay quiet.
  // The "1001" that follows them is detected.
  task automatic test_near_miss();
    logic [22:0] j_v = {1'b0, 4'b1011, 4'b1000, 4'b0001, 5'b10001, 4'b1001, 1'b0};
    logic [22:0] r_v = {1'b1, 22'b0};
    logic [22:0] e_v = {1'b0, 4'b0000, 4'b0000, 4'b0000, 5'b00000, 4'b0001, 1'b0};
    for (int i = 22; i >= 0; i--) begin
      step(j_v[i], r_v[i]);
      tests_run++;
      if (mealy_if.w !== e_v[i]) begin
        tests_failed++;
        $display("FAIL near_miss_mealy step %0d: got %b required %b", 23 - i, mealy_if.w, e_v[i]);
      end
      tests_run++;
      if (moore_if.w !== moore_exp) begin
        tests_failed++;
        $display("FAIL near_miss_moore step %0d: got %b required %b", 23 - i, moore_if.w, moore_exp);
      end
      moore_exp = e_v[i] & ~r_v[i];
    end
  endtask

  // Apply "100" with rst high at the edge of the last '0', then j=1: no detect.
  // A fresh "1001" afterwards must detect.
  task automatic test_mid_reset();
    logic [10:0] j_v = {1'b0, 3'b100, 1'b1, 4'b1001, 2'b00};
    logic [10:0] r_v = {1'b1, 3'b001, 1'b0, 4'b0000, 2'b00};
    logic [10:0] e_v = {1'b0, 3'b000, 1'b0, 4'b0001, 2'b00};
    for (int i = 10; i >= 0; i--) begin
      step(j_v[i], r_v[i]);
      tests_run++;
      if (mealy_if.w !== e_v[i]) begin
        tests_failed++;
        $display("FAIL mid_reset_mealy step %0d: got %b required %b", 11 - i, mealy_if.w, e_v[i]);
      end
      tests_run++;
      if (moore_if.w !== moore_exp) begin
        tests_failed++;
        $display("FAIL mid_reset_moore step %0d: got %b required %b", 11 - i, moore_if.w, moore_exp);
      end
      moore_exp = e_v[i] & ~r_v[i];
    end
  endtask

  initial begin
    rst        = 1'b0;
    moore_if.j = 1'b0;
    mealy_if.j = 1'b0;

    test_no_reset_start();
    test_reset();
    test_basic_match();
    test_overlap();
    test_near_miss();
    test_mid_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
